interval_capture: RTL

//  Measures the interval between a START and a STOP event by counting enabled

---
 rtl/counter_pkg.sv | 12 +
 rtl/sat_up_counter.sv | 38 +++
 rtl/interval_capture.sv | 101 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the count/time datapath blocks.
package counter_pkg;

   localparam int unsigned DEFAULT_BITWIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } icap_state_t;

endpackage : counter_pkg

// File: rtl/sat_up_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_up_counter #(
   parameter int unsigned bitwidth = 32
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CLR,
   input  logic                EN,
   output logic [bitwidth-1:0] Q,
   output logic                SAT
);

   localparam logic [bitwidth-1:0] MAX_COUNT = '1;

   logic [bitwidth-1:0] r_q;
   logic                r_sat;

   // Clear beats enable; at all-ones an enable only raises the sticky flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_q   <= '0;
         r_sat <= 1'b0;
      end else if (CLR) begin
         r_q   <= '0;
         r_sat <= 1'b0;
      end else if (EN) begin
         if (r_q == MAX_COUNT) begin
            r_sat <= 1'b1;
         end else begin
            r_q <= r_q + bitwidth'(1);
         end
      end
   end

   assign Q   = r_q;
   assign SAT = r_sat;

endmodule : sat_up_counter

// File: rtl/interval_capture.sv
// Counts enabled cycles between START and STOP and offers the result on a val/rdy port.
module interval_capture
   import counter_pkg::*;
#(
   parameter int unsigned bitwidth = DEFAULT_BITWIDTH
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                START,
   input  logic                STOP,
   input  logic                EN,
   output logic [bitwidth-1:0] OUT,
   output logic                OUT_OVF,
   output logic                OUT_VAL,
   input  logic                OUT_RDY,
   output logic                BUSY
);

   icap_state_t         r_state;
   logic [bitwidth-1:0] r_out;
   logic                r_ovf;
   logic                r_val;
   logic                r_busy;

   logic [bitwidth-1:0] w_q;
   logic                w_sat;
   logic                w_hs;
   logic                w_clr;
   logic                w_cnt_en;

   assign w_hs = r_val & OUT_RDY;

   // Counter restarts on every transition into a fresh measurement.
   assign w_clr = ((r_state == IDLE)  & START) |
                  ((r_state == COUNT) & START & ~STOP) |
                  ((r_state == HOLD)  & w_hs & START);

   assign w_cnt_en = (r_state == COUNT) & EN & ~STOP & ~START;

   sat_up_counter #(
      .bitwidth(bitwidth)
   ) u_counter (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLR   (w_clr),
      .EN    (w_cnt_en),
      .Q     (w_q),
      .SAT   (w_sat)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_out   <= '0;
         r_ovf   <= 1'b0;
         r_val   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_state <= COUNT;
                  r_busy  <= 1'b1;
               end
            end
            COUNT: begin
               // Capture uses the count as it stood before this cycle's EN.
               if (STOP) begin
                  r_state <= HOLD;
                  r_busy  <= 1'b0;
                  r_val   <= 1'b1;
                  r_out   <= w_q;
                  r_ovf   <= w_sat;
               end
            end
            HOLD: begin
               if (w_hs) begin
                  r_val <= 1'b0;
                  if (START) begin
                     r_state <= COUNT;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_val   <= 1'b0;
            end
         endcase
      end
   end

   assign OUT     = r_out;
   assign OUT_OVF = r_ovf;
   assign OUT_VAL = r_val;
   assign BUSY    = r_busy;

endmodule : interval_capture
